// File: rtl/boron_dec_iterator.sv
// Iterative Boron decryption engine: final-whitening key, then one inverse round per clock
// with round keys walked from ROUNDS-1 down to 0 out of an external zero-latency key store.

// One combinational inverse Boron round: undo XOR mixing, rotate words right, inverse S-box.
module boron_dec_round #(
  localparam int unsigned BLOCK_W = 64,
  localparam int unsigned WORD_W  = 16
) (
  input  logic [BLOCK_W-1:0] current_text_i,
  output logic [BLOCK_W-1:0] updated_text_o
);

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hA;
      4'h1: r = 4'h3;
      4'h2: r = 4'h9;
      4'h3: r = 4'hE;
      4'h4: r = 4'h1;
      4'h5: r = 4'hD;
      4'h6: r = 4'hF;
      4'h7: r = 4'h4;
      4'h8: r = 4'hC;
      4'h9: r = 4'h5;
      4'hA: r = 4'h7;
      4'hB: r = 4'h2;
      4'hC: r = 4'h6;
      4'hD: r = 4'h8;
      4'hE: r = 4'h0;
      default: r = 4'hB;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] w, input int unsigned r);
    return (w >> r) | (w << (WORD_W - r));
  endfunction

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] u1, u2, u3;
  logic [BLOCK_W-1:0] rotated;

  assign w0 = current_text_i[0*WORD_W +: WORD_W];
  assign w1 = current_text_i[1*WORD_W +: WORD_W];
  assign w2 = current_text_i[2*WORD_W +: WORD_W];
  assign w3 = current_text_i[3*WORD_W +: WORD_W];

  // Mixing is undone in reverse order of the forward round (w1^=w0, w2^=w3, w3^=w1).
  assign u3 = w3 ^ w1;
  assign u2 = w2 ^ u3;
  assign u1 = w1 ^ w0;

  assign rotated = {rotr(u3, 9), rotr(u2, 7), rotr(u1, 4), rotr(w0, 1)};

  always_comb begin
    updated_text_o = '0;
    for (int i = 0; i < BLOCK_W / 4; i++) begin
      updated_text_o[4*i +: 4] = inv_sbox(rotated[4*i +: 4]);
    end
  end

endmodule

module boron_dec_iterator #(
  parameter int unsigned ROUNDS    = 25,
  parameter int unsigned KEY_IDX_W = 5,
  localparam int unsigned BLOCK_W  = 64
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  output logic                 Start_Ready,
  input  logic [BLOCK_W-1:0]   Cipher_Text,
  output logic [KEY_IDX_W-1:0] Round_Key_Idx,
  input  logic [BLOCK_W-1:0]   Round_Key,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [BLOCK_W-1:0]   Plain_Text
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam logic [KEY_IDX_W-1:0] LAST_KEY_IDX  = KEY_IDX_W'(ROUNDS);
  localparam logic [KEY_IDX_W-1:0] FIRST_RND_IDX = KEY_IDX_W'(ROUNDS - 1);

  state_e               fsm_q, fsm_d;
  logic [BLOCK_W-1:0]   text_q, text_d;
  logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
  logic [BLOCK_W-1:0]   updated_text;

  logic                 start_ready_q, start_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0]   plain_q, plain_d;
  logic [KEY_IDX_W-1:0] key_idx_q, key_idx_d;

  boron_dec_round u_dec_round (
    .current_text_i (text_q),
    .updated_text_o (updated_text)
  );

  // State register plus output registers, all cleared asynchronously.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fsm_q         <= ST_IDLE;
      text_q        <= '0;
      rnd_q         <= '0;
      start_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
      plain_q       <= '0;
      key_idx_q     <= LAST_KEY_IDX;
    end else begin
      fsm_q         <= fsm_d;
      text_q        <= text_d;
      rnd_q         <= rnd_d;
      start_ready_q <= start_ready_d;
      out_valid_q   <= out_valid_d;
      plain_q       <= plain_d;
      key_idx_q     <= key_idx_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they land registered.
  always_comb begin
    fsm_d  = fsm_q;
    text_d = text_q;
    rnd_d  = rnd_q;

    case (fsm_q)
      ST_IDLE: begin
        if (Start) begin
          text_d = Cipher_Text ^ Round_Key;
          rnd_d  = FIRST_RND_IDX;
          fsm_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        text_d = updated_text ^ Round_Key;
        if (rnd_q == '0) begin
          fsm_d = ST_OUT;
        end else begin
          rnd_d = rnd_q - 1'b1;
        end
      end
      ST_OUT: begin
        if (Out_Ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    start_ready_d = (fsm_d == ST_IDLE);
    out_valid_d   = (fsm_d == ST_OUT);
    plain_d       = (fsm_d == ST_OUT) ? text_d : '0;
    key_idx_d     = (fsm_d == ST_RUN) ? rnd_d : LAST_KEY_IDX;
  end

  assign Start_Ready   = start_ready_q;
  assign Out_Valid     = out_valid_q;
  assign Plain_Text    = plain_q;
  assign Round_Key_Idx = key_idx_q;

endmodule

// File: tb/tb_boron_dec_iterator.sv
// Randomized self-checking bench for boron_dec_iterator against a nibble/word level
// Boron model that includes the forward cipher for round-trip checks.
module tb_boron_dec_iterator;

  localparam int ROUNDS    = 25;
  localparam int KEY_IDX_W = 5;

  localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                       4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  localparam int ROT [4] = '{1, 4, 7, 9};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 start_ready;
  logic [63:0]          cipher;
  logic [KEY_IDX_W-1:0] round_key_idx;
  logic [63:0]          round_key;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          plain;

  logic [63:0] kmem [32];
  int checks   = 0;
  int failures = 0;

  assign round_key = kmem[round_key_idx];

  always #5 clk = ~clk;

  boron_dec_iterator #(.ROUNDS(ROUNDS), .KEY_IDX_W(KEY_IDX_W)) dut (
    .Clk           (clk),
    .Rst_n         (rst_n),
    .Start         (start),
    .Start_Ready   (start_ready),
    .Cipher_Text   (cipher),
    .Round_Key_Idx (round_key_idx),
    .Round_Key     (round_key),
    .Out_Valid     (out_valid),
    .Out_Ready     (out_ready),
    .Plain_Text    (plain)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] enc_round(input logic [63:0] x);
    logic [63:0] s;
    logic [15:0] w [4];
    logic [15:0] v;
    for (int i = 0; i < 16; i++) s[4*i +: 4] = SBOX[x[4*i +: 4]];
    for (int j = 0; j < 4; j++) begin
      v = s[16*j +: 16];
      for (int b = 0; b < 16; b++) w[j][(b + ROT[j]) % 16] = v[b];
    end
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[3];
    w[3] = w[3] ^ w[1];
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [63:0] dec_round(input logic [63:0] x);
    logic [15:0] w [4];
    logic [63:0] r;
    logic [63:0] s;
    for (int j = 0; j < 4; j++) w[j] = x[16*j +: 16];
    w[3] = w[3] ^ w[1];
    w[2] = w[2] ^ w[3];
    w[1] = w[1] ^ w[0];
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 16; b++) r[16*j + b] = w[j][(b + ROT[j]) % 16];
    s = '0;
    for (int i = 0; i < 16; i++)
      for (int v = 0; v < 16; v++)
        if (SBOX[v] == r[4*i +: 4]) s[4*i +: 4] = 4'(v);
    return s;
  endfunction

  function automatic logic [63:0] model_encrypt(input logic [63:0] p);
    logic [63:0] s;
    s = p ^ kmem[0];
    for (int r = 1; r <= ROUNDS; r++) s = enc_round(s) ^ kmem[r];
    return s;
  endfunction

  function automatic logic [63:0] model_decrypt(input logic [63:0] c);
    logic [63:0] s;
    s = c ^ kmem[ROUNDS];
    for (int r = ROUNDS - 1; r >= 0; r--) s = dec_round(s) ^ kmem[r];
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " start_ready"}, 64'(start_ready), 64'd1);
    check_eq({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, " plain"}, plain, 64'd0);
    check_eq({tag, " key_idx"}, 64'(round_key_idx), 64'(ROUNDS));
  endtask

  // One full block: accept, track key index walk and latency, hold OUT, handshake.
  task automatic run_block(input logic [63:0] ct, input logic [63:0] exp, input int hold,
                           input bit poke, input string tag);
    int lat, n_idx, idx_err, unstable;
    logic [63:0] held;
    for (int i = 0; i < 100 && !start_ready; i++) tick();
    check_eq({tag, " ready_before_start"}, 64'(start_ready), 64'd1);
    check_eq({tag, " idx_at_accept"}, 64'(round_key_idx), 64'(ROUNDS));
    start  = 1'b1;
    cipher = ct;
    tick();
    start  = 1'b0;
    cipher = {$urandom, $urandom};
    lat = 1; n_idx = 0; idx_err = 0;
    while (!out_valid && lat < 200) begin
      if (int'(round_key_idx) != ROUNDS - 1 - n_idx) idx_err++;
      if (start_ready) idx_err++;
      start = poke && (n_idx == 5);
      n_idx++;
      tick();
      lat++;
    end
    start = 1'b0;
    check_eq({tag, " latency_edges"}, 64'(lat), 64'(ROUNDS + 1));
    check_eq({tag, " key_idx_count"}, 64'(n_idx), 64'(ROUNDS));
    check_eq({tag, " key_idx_seq_err"}, 64'(idx_err), 64'd0);
    check_eq({tag, " plain"}, plain, exp);
    held = plain;
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      start = poke && (h == 3);
      tick();
      if (plain !== held || out_valid !== 1'b1 || start_ready !== 1'b0) unstable++;
    end
    start = 1'b0;
    check_eq({tag, " hold_stable_err"}, 64'(unstable), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle({tag, " after_handshake"});
    if (poke) begin
      tick();
      check_eq({tag, " no_queued_start"}, 64'(start_ready), 64'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] ct, pt, exp;
    logic [63:0] cts [4];
    logic [63:0] res [4];
    int acc_cyc [4];
    int n_acc, n_out, cyc;

    for (int i = 0; i < 32; i++) kmem[i] = '0;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; cipher = '0;
    #12;
    check_idle("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Zero keys, zero ciphertext
    run_block(64'd0, model_decrypt(64'd0), 0, 1'b0, "zero");

    // Arithmetic key schedule with random ciphertext
    for (int i = 0; i < 32; i++) kmem[i] = 64'h0101_0101_0101_0101 * 64'(i);
    ct = {$urandom, $urandom};
    run_block(ct, model_decrypt(ct), 0, 1'b0, "ramp_keys");

    // Round trip through the forward cipher
    pt = 64'h0123_4567_89AB_CDEF;
    run_block(model_encrypt(pt), pt, 0, 1'b0, "round_trip");

    // Backpressure with Start pulses during RUN and OUT
    ct = {$urandom, $urandom};
    run_block(ct, model_decrypt(ct), 10, 1'b1, "backpressure");

    // Asynchronous reset in the middle of RUN
    ct = {$urandom, $urandom};
    start = 1'b1; cipher = ct;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check_eq("mid_run busy", 64'(start_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    ct = {$urandom, $urandom};
    run_block(ct, model_decrypt(ct), 1, 1'b0, "after_reset");

    // Back-to-back with Start and Out_Ready held high
    for (int i = 0; i < 32; i++) kmem[i] = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) cts[k] = {$urandom, $urandom};
    n_acc = 0; n_out = 0; cyc = 0;
    out_ready = 1'b1;
    start = 1'b1;
    while (n_out < 4 && cyc < 400) begin
      if (out_valid) begin
        res[n_out] = plain;
        n_out++;
      end
      if (start_ready && n_acc < 4) begin
        cipher = cts[n_acc];
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else if (n_acc == 4) begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0; out_ready = 1'b0;
    check_eq("b2b outputs", 64'(n_out), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_out) check_eq($sformatf("b2b plain[%0d]", k), res[k], model_decrypt(cts[k]));
      if (k > 0 && k < n_acc)
        check_eq($sformatf("b2b interval[%0d]", k), 64'(acc_cyc[k] - acc_cyc[k-1]),
                 64'(ROUNDS + 2));
    end

    // Random keys, ciphertexts and backpressure
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 32; i++) kmem[i] = {$urandom, $urandom};
      pt = {$urandom, $urandom};
      run_block(model_encrypt(pt), pt, int'($urandom_range(0, 4)), 1'b0,
                $sformatf("rand%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
